// File: rtl/mac_array4_if.sv
// Bus bundle for mac_array4: A/B term inputs, start pulse, dot-product results and schedule outputs.
// The master side drives terms and start; the slave side (the MAC array) returns results.
interface mac_array4_if;
  logic               start;
  logic signed [7:0]  a_in;
  logic signed [7:0]  b_in1;
  logic signed [7:0]  b_in2;
  logic signed [7:0]  b_in3;
  logic signed [7:0]  b_in4;
  logic signed [18:0] mac_out1;
  logic signed [18:0] mac_out2;
  logic signed [18:0] mac_out3;
  logic signed [18:0] mac_out4;
  logic               out_valid;
  logic [10:0]        clock_count;
  logic               busy;
  logic               done;

  modport master (
    output start, a_in, b_in1, b_in2, b_in3, b_in4,
    input  mac_out1, mac_out2, mac_out3, mac_out4, out_valid, clock_count, busy, done
  );

  modport slave (
    input  start, a_in, b_in1, b_in2, b_in3, b_in4,
    output mac_out1, mac_out2, mac_out3, mac_out4, out_valid, clock_count, busy, done
  );
endinterface

// File: rtl/mac_array4.sv
// Four-lane signed MAC: broadcast A element times per-lane B element, DOT_LEN-term dot products,
// plus the clock_count schedule that the downstream serializer keys its slots to.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; inputs ignored, clock_count holds
// S_RUN   | sampling one term per cycle, publishing every DOT_LEN terms
// S_DRAIN | clock_count keeps counting DRAIN cycles for downstream flush
module mac_array4 #(
  parameter int DOT_LEN    = 8,
  parameter int NUM_GROUPS = 16,
  parameter int DRAIN      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mac_array4_if.slave bus
);
  localparam int TW = $clog2(DOT_LEN);
  localparam int GW = $clog2(NUM_GROUPS);
  localparam int DW = $clog2(DRAIN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic signed [18:0] acc_q [4];
  logic signed [18:0] acc_d [4];
  logic signed [18:0] mac_q [4];
  logic signed [18:0] mac_d [4];
  logic signed [15:0] p16   [4];
  logic signed [18:0] prod  [4];
  logic signed [7:0]  b_lane[4];
  logic [TW-1:0]      term_q, term_d;
  logic [GW-1:0]      grp_q, grp_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [10:0]        cc_q, cc_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  assign b_lane[0] = bus.b_in1;
  assign b_lane[1] = bus.b_in2;
  assign b_lane[2] = bus.b_in3;
  assign b_lane[3] = bus.b_in4;

  // 8x8 signed product always fits 16 bits; sign-extend to accumulator width
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      p16[i]  = 16'(bus.a_in) * 16'(b_lane[i]);
      prod[i] = 19'(p16[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mac_d   = mac_q;
    term_d  = term_q;
    grp_d   = grp_q;
    drain_d = drain_q;
    cc_d    = cc_q;
    valid_d = 1'b0;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          cc_d    = '0;
          term_d  = '0;
          grp_d   = '0;
          done_d  = 1'b0;
          for (int i = 0; i < 4; i++) acc_d[i] = '0;
        end
      end
      S_RUN: begin
        cc_d = cc_q + 11'd1;
        if (term_q == TW'(DOT_LEN - 1)) begin
          for (int i = 0; i < 4; i++) begin
            mac_d[i] = acc_q[i] + prod[i];
            acc_d[i] = '0;
          end
          term_d  = '0;
          valid_d = 1'b1;
          if (grp_q == GW'(NUM_GROUPS - 1)) begin
            state_d = S_DRAIN;
            drain_d = DW'(DRAIN - 1);
          end else begin
            grp_d = grp_q + GW'(1);
          end
        end else begin
          for (int i = 0; i < 4; i++) acc_d[i] = acc_q[i] + prod[i];
          term_d = term_q + TW'(1);
        end
      end
      S_DRAIN: begin
        cc_d = cc_q + 11'd1;
        if (drain_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
        mac_q[i] <= '0;
      end
      term_q  <= '0;
      grp_q   <= '0;
      drain_q <= '0;
      cc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mac_q   <= mac_d;
      term_q  <= term_d;
      grp_q   <= grp_d;
      drain_q <= drain_d;
      cc_q    <= cc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.mac_out1    = mac_q[0];
  assign bus.mac_out2    = mac_q[1];
  assign bus.mac_out3    = mac_q[2];
  assign bus.mac_out4    = mac_q[3];
  assign bus.out_valid   = valid_q;
  assign bus.clock_count = cc_q;
  assign bus.busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done        = done_q;
endmodule

// File: tb/tb_mac_array4.sv
// Directed bench for mac_array4: table of per-group constant terms with hand-computed dot products,
// full runs (plain and with stray start pulses), and a mid-run reset sequence.
module tb_mac_array4;
  localparam int TOTAL = 136;

  typedef struct {
    logic signed [7:0] a;
    logic signed [7:0] b[4];
    int                exp[4];
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_array4_if bus();

  mac_array4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[8];
  int   hold[4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [7:0] a, input logic signed [7:0] b1,
                       input logic signed [7:0] b2, input logic signed [7:0] b3,
                       input logic signed [7:0] b4);
    bus.a_in  = a;
    bus.b_in1 = b1;
    bus.b_in2 = b2;
    bus.b_in3 = b3;
    bus.b_in4 = b4;
  endtask

  task automatic set_vec(input int i, input int a, input int b1, input int b2, input int b3,
                         input int b4, input int e1, input int e2, input int e3, input int e4);
    tbl[i].a      = 8'(a);
    tbl[i].b[0]   = 8'(b1);
    tbl[i].b[1]   = 8'(b2);
    tbl[i].b[2]   = 8'(b3);
    tbl[i].b[3]   = 8'(b4);
    tbl[i].exp[0] = e1;
    tbl[i].exp[1] = e2;
    tbl[i].exp[2] = e3;
    tbl[i].exp[3] = e4;
  endtask

  task automatic chk_outs(input string tag, input int e1, input int e2, input int e3, input int e4);
    chk({tag, "_mac1"}, int'(bus.mac_out1), e1);
    chk({tag, "_mac2"}, int'(bus.mac_out2), e2);
    chk({tag, "_mac3"}, int'(bus.mac_out3), e3);
    chk({tag, "_mac4"}, int'(bus.mac_out4), e4);
  endtask

  task automatic run_full(input bit disturb);
    int pulses;
    int eg;
    pulses   = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_cc", int'(bus.clock_count), 0);
    chk("start_busy", int'(bus.busy), 1);
    chk("start_done", int'(bus.done), 0);
    for (int cyc = 1; cyc <= TOTAL; cyc++) begin
      if (cyc <= 128) begin
        eg = ((cyc - 1) / 8) % 8;
        drive(tbl[eg].a, tbl[eg].b[0], tbl[eg].b[1], tbl[eg].b[2], tbl[eg].b[3]);
      end else begin
        drive(8'sd55, -8'sd7, 8'sd99, -8'sd128, 8'sd127);
      end
      bus.start = disturb && (cyc == 6 || cyc == 131 || cyc == TOTAL);
      step();
      bus.start = 1'b0;
      if (bus.out_valid) pulses++;
      chk("run_cc", int'(bus.clock_count), cyc);
      chk("run_busy", int'(bus.busy), (cyc < TOTAL) ? 1 : 0);
      chk("run_done", int'(bus.done), (cyc == TOTAL) ? 1 : 0);
      chk("run_valid", int'(bus.out_valid), (cyc % 8 == 0 && cyc <= 128) ? 1 : 0);
      if (cyc < 8) begin
        chk_outs("run_pre", hold[0], hold[1], hold[2], hold[3]);
      end else begin
        eg = cyc / 8 - 1;
        if (eg > 15) eg = 15;
        eg = eg % 8;
        chk_outs("run_grp", tbl[eg].exp[0], tbl[eg].exp[1], tbl[eg].exp[2], tbl[eg].exp[3]);
      end
    end
    chk("run_pulses", pulses, 16);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_cc", int'(bus.clock_count), TOTAL);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_done", int'(bus.done), 1);
      chk("idle_valid", int'(bus.out_valid), 0);
    end
    for (int i = 0; i < 4; i++) hold[i] = tbl[7].exp[i];
  endtask

  initial begin
    set_vec(0,    1,    1,    2,    3,    4,       8,      16,      24,     32);
    set_vec(1,    2,    3,   -3,    5,   -7,      48,     -48,      80,   -112);
    set_vec(2, -128, -128, -128, -128, -128,  131072,  131072,  131072, 131072);
    set_vec(3, -128,  127,   -1,    0,    1, -130048,    1024,       0,  -1024);
    set_vec(4,  127,  127, -128,    1,   -1,  129032, -130048,    1016,  -1016);
    set_vec(5,    0,    5,    6,    7,    8,       0,       0,       0,      0);
    set_vec(6,   -1,    1,    2,   -3,  100,      -8,     -16,      24,   -800);
    set_vec(7,   10,   10,  -10,   12,  -12,     800,    -800,     960,   -960);
    for (int i = 0; i < 4; i++) hold[i] = 0;

    bus.start = 1'b0;
    drive(8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
    #12;
    chk("rst_cc", int'(bus.clock_count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk_outs("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'sd9, 8'sd9, 8'sd9, 8'sd9, 8'sd9);
    step();
    step();
    chk("idle0_cc", int'(bus.clock_count), 0);
    chk("idle0_busy", int'(bus.busy), 0);

    run_full(1'b0);
    run_full(1'b1);

    // mid-run reset at clock_count 20, then a fresh run with per-term varying data
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      drive(8'sd1, 8'sd1, 8'sd2, 8'sd3, 8'sd4);
      step();
      chk("mr_cc", int'(bus.clock_count), cyc);
    end
    chk_outs("mr_pre", 8, 16, 24, 32);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_cc", int'(bus.clock_count), 0);
    chk("mr_rst_busy", int'(bus.busy), 0);
    chk("mr_rst_done", int'(bus.done), 0);
    chk("mr_rst_valid", int'(bus.out_valid), 0);
    chk_outs("mr_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int t = 0; t < 8; t++) begin
      drive(8'(t + 1), 8'sd1, -8'sd1, 8'(t), 8'sd2);
      step();
      chk("rr_cc", int'(bus.clock_count), t + 1);
      if (t < 7) begin
        chk("rr_valid_lo", int'(bus.out_valid), 0);
        chk_outs("rr_pre", 0, 0, 0, 0);
      end
    end
    chk("rr_valid", int'(bus.out_valid), 1);
    chk_outs("rr_res", 36, -36, 168, 72);
    drive(8'sd3, 8'sd3, 8'sd3, 8'sd3, 8'sd3);
    step();
    chk("rr_valid_drop", int'(bus.out_valid), 0);
    chk("rr_cc9", int'(bus.clock_count), 9);
    chk_outs("rr_hold", 36, -36, 168, 72);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
